// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the PS/2 keyboard receiver: scancodes, held-key
// index order, frame FSM state encoding, decoded event payload and the
// scancode-to-key lookup.
package ps2_pkg;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_RIGHT   = 8'h74;
    localparam logic [7:0] SC_JUMP    = 8'h12;
    localparam logic [7:0] SC_SHOOT   = 8'h1A;
    localparam logic [7:0] SC_RESTART = 8'h2D;

    localparam int unsigned NUM_KEYS    = 5;
    localparam int unsigned KEY_LEFT    = 0;
    localparam int unsigned KEY_RIGHT   = 1;
    localparam int unsigned KEY_JUMP    = 2;
    localparam int unsigned KEY_SHOOT   = 3;
    localparam int unsigned KEY_RESTART = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // One-hot mask of the held-key bit addressed by an event (zero if none).
    function automatic logic [NUM_KEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        if (ext) begin
            if (code == SC_LEFT)  m[KEY_LEFT]  = 1'b1;
            if (code == SC_RIGHT) m[KEY_RIGHT] = 1'b1;
        end else begin
            if (code == SC_JUMP)    m[KEY_JUMP]    = 1'b1;
            if (code == SC_SHOOT)   m[KEY_SHOOT]   = 1'b1;
            if (code == SC_RESTART) m[KEY_RESTART] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
`timescale 1ns/1ps
// PS/2 line conditioning: two-flop synchronisers on clock and data, a
// level filter on the clock, and falling-edge detection of the filtered
// clock producing a one-cycle bit strobe.
// Ports: clk, clrn (async active-low), ps2_clk, ps2_data (raw lines),
//        strobe (bit strobe), data (synchronised data aligned to strobe).
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic strobe,
    output logic data
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             filt;
    logic [CNT_W-1:0] cnt;
    logic             flip_c;

    // Filtered level toggles on the FILTER_LEN-th consecutive differing sample.
    assign flip_c = (clk_sync[1] != filt) && (cnt == CNT_W'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt      <= 1'b1;
            cnt       <= '0;
            strobe    <= 1'b0;
            data      <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            strobe    <= flip_c & filt;
            data      <= data_sync[1];
            if (clk_sync[1] == filt) begin
                cnt <= '0;
            end else if (flip_c) begin
                filt <= ~filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: frames bytes from the keyboard, folds E0/F0
// prefixes into decoded key events and tracks five held-key levels.
// Ports: clk, clrn (async active-low), ps2_clk, ps2_data (keyboard lines),
//        code_valid/code/code_ext/code_break (decoded event), frame_err
//        (error pulse), keys (held-key levels).
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TIMEOUT_US = 100,
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic                code_valid,
    output logic [7:0]          code,
    output logic                code_ext,
    output logic                code_break,
    output logic                frame_err,
    output logic [NUM_KEYS-1:0] keys
);

    localparam int unsigned TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TO_W   = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;

    logic bit_strobe;
    logic bit_data;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .strobe   (bit_strobe),
        .data     (bit_data)
    );

    ps2_state_t          state, state_n;
    logic [2:0]          bit_cnt, bit_cnt_n;
    logic [7:0]          shift, shift_n;
    logic                par_ok, par_ok_n;
    logic [TO_W-1:0]     to_cnt, to_cnt_n;
    logic                ext_pend, ext_pend_n;
    logic                brk_pend, brk_pend_n;
    ps2_event_t          evt, evt_n;
    logic                valid_n;
    logic                err_n;
    logic [NUM_KEYS-1:0] keys_n;
    logic [NUM_KEYS-1:0] mask_c;

    assign mask_c = key_mask(ext_pend, shift);

    // State and output registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_ok     <= 1'b0;
            to_cnt     <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            evt        <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            keys       <= '0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par_ok     <= par_ok_n;
            to_cnt     <= to_cnt_n;
            ext_pend   <= ext_pend_n;
            brk_pend   <= brk_pend_n;
            evt        <= evt_n;
            code_valid <= valid_n;
            frame_err  <= err_n;
            keys       <= keys_n;
        end
    end

    assign code       = evt.code;
    assign code_ext   = evt.ext;
    assign code_break = evt.brk;

    // Frame FSM, timeout, prefix folding and held-key update.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        par_ok_n   = par_ok;
        to_cnt_n   = to_cnt;
        ext_pend_n = ext_pend;
        brk_pend_n = brk_pend;
        evt_n      = evt;
        valid_n    = 1'b0;
        err_n      = 1'b0;
        keys_n     = keys;

        if (bit_strobe) begin
            to_cnt_n = '0;
            case (state)
                IDLE: begin
                    if (!bit_data) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                DATA: begin
                    shift_n = {bit_data, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    par_ok_n = ^{bit_data, shift};
                    state_n  = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (bit_data && par_ok) begin
                        if (shift == SC_EXT) begin
                            ext_pend_n = 1'b1;
                        end else if (shift == SC_BREAK) begin
                            brk_pend_n = 1'b1;
                        end else begin
                            valid_n    = 1'b1;
                            evt_n.code = shift;
                            evt_n.ext  = ext_pend;
                            evt_n.brk  = brk_pend;
                            ext_pend_n = 1'b0;
                            brk_pend_n = 1'b0;
                            keys_n     = brk_pend ? (keys & ~mask_c) : (keys | mask_c);
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            // Keyboard stopped clocking mid-frame: drop the partial byte.
            if (to_cnt == TO_W'(TO_CYC)) begin
                state_n  = IDLE;
                err_n    = 1'b1;
                to_cnt_n = '0;
            end else begin
                to_cnt_n = to_cnt + TO_W'(1);
            end
        end else begin
            to_cnt_n = '0;
        end
    end

endmodule
